// File: rtl/regfile_param.sv
// Parameterised register file with a per-register pending-write scoreboard.
//
// Ports:
//   clk           - clock; all state updates on the rising edge
//   reset         - asynchronous active-low reset; clears data and scoreboard
//   RegWrite      - write enable
//   WriteRegister - write address
//   WriteData     - write data
//   ReadRegister  - NREAD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   ReadData      - NREAD packed read data, same slice order as ReadRegister
//   IssueValid    - a producer claims IssueRegister as its destination this cycle
//   IssueRegister - claimed destination address
//   Busy          - per read port: the addressed register has a pending write
//
// ZERO_REG = -1 disables the hardwired-zero register. BYPASS = 1 forwards a
// same-cycle write to matching read ports and hides its scoreboard bit.
module regfile_param #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NREAD    = 2,
    parameter int          ZERO_REG = 31,
    parameter bit          BYPASS   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWrite,
    input  logic [ADDR_W-1:0]         WriteRegister,
    input  logic [DATA_W-1:0]         WriteData,
    input  logic [NREAD*ADDR_W-1:0]   ReadRegister,
    output logic [NREAD*DATA_W-1:0]   ReadData,
    input  logic                      IssueValid,
    input  logic [ADDR_W-1:0]         IssueRegister,
    output logic [NREAD-1:0]          Busy
);

    localparam int unsigned       Depth    = 2 ** ADDR_W;
    localparam bit                HasZero  = (ZERO_REG >= 0);
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(HasZero ? ZERO_REG : 0);

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return HasZero && (addr == ZeroAddr);
    endfunction

    logic [DATA_W-1:0] regs_q [Depth];
    logic [Depth-1:0]  busy_q;
    logic [Depth-1:0]  busy_d;
    logic              wr_en;
    logic              iss_en;

    // The zero register is never written nor marked busy.
    assign wr_en  = RegWrite && !is_zero(WriteRegister);
    assign iss_en = IssueValid && !is_zero(IssueRegister);

    // Clear first, then set: a same-cycle issue to the written register wins
    // because it represents a newer producer.
    always_comb begin
        busy_d = busy_q;
        if (RegWrite) begin
            busy_d[WriteRegister] = 1'b0;
        end
        if (iss_en) begin
            busy_d[IssueRegister] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[WriteRegister] <= WriteData;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic              claim;

        assign addr  = ReadRegister[k*ADDR_W +: ADDR_W];
        assign hit   = BYPASS && wr_en && (addr == WriteRegister);
        assign claim = iss_en && (IssueRegister == addr);

        // Outputs are forced to zero while reset is held so a bypassed write
        // cannot leak through during reset.
        assign ReadData[k*DATA_W +: DATA_W] =
            (!reset || is_zero(addr)) ? '0 :
            hit                       ? WriteData :
                                        regs_q[addr];

        // A forwarded write resolves the pending value, unless a new producer
        // claims the same register in this cycle.
        assign Busy[k] = reset && busy_q[addr] && !(hit && !claim);
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Parameters
REQ-001 SHALL have parameter DATA_W, default 64, meaning the width of each register in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter NREAD, default 2, meaning the number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 31, meaning the index of the hardwired-zero register; value -1 means there is no zero register.
REQ-005 SHALL have parameter BYPASS, default 1, meaning write-through forwarding: 1 enables it, 0 disables it.

Interface
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port RegWrite, input, 1 bit: write enable.
REQ-009 SHALL have port WriteRegister, input, ADDR_W bits: write address.
REQ-010 SHALL have port WriteData, input, DATA_W bits: write data.
REQ-011 SHALL have port ReadRegister, input, NREAD*ADDR_W bits: packed read addresses; port k occupies slice [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port ReadData, output, NREAD*DATA_W bits: packed read data, with the same slice order as ReadRegister.
REQ-013 SHALL have port IssueValid, input, 1 bit: a pipeline producer has claimed a destination this cycle.
REQ-014 SHALL have port IssueRegister, input, ADDR_W bits: the claimed destination address.
REQ-015 SHALL have port Busy, output, NREAD bits: per read port, the addressed register has a pending write.

Function
REQ-016 SHALL write WriteData into register WriteRegister at the rising clk edge when RegWrite=1.
REQ-017 SHALL ignore writes addressed to ZERO_REG; that register SHALL always read 0 and never be busy.
REQ-018 SHALL make reads combinational: ReadData slice k = contents of ReadRegister slice k, with zero latency.
REQ-019 When BYPASS=1, RegWrite=1 and WriteRegister equals read address k (not ZERO_REG), read port k SHALL return WriteData in the same cycle.
REQ-020 When BYPASS=0, the written value SHALL be visible on reads only from the cycle after the write edge.
REQ-021 SHALL keep one scoreboard bit per register; IssueValid=1 SHALL set bit[IssueRegister] at the clk edge, except for ZERO_REG.
REQ-022 A RegWrite=1 edge SHALL clear bit[WriteRegister].
REQ-023 If issue and write target the same register in the same cycle, issue SHALL win and the bit SHALL remain set (a new producer).
REQ-024 Issue and write to different registers in the same cycle SHALL both take effect.
REQ-025 Busy[k] SHALL equal bit[ReadRegister k], masked to 0 when BYPASS=1 and the same-cycle write hits that address with no same-cycle issue to it.
REQ-026 Writing a register whose scoreboard bit is clear SHALL be legal; the data SHALL update and the bit SHALL stay clear.
REQ-027 All read ports SHALL be independent; identical addresses on several ports SHALL return identical data and Busy.
REQ-028 Address width SHALL be exact: every register 0..2**ADDR_W-1 is addressable, with no aliasing.

Reset
REQ-029 reset=0 SHALL asynchronously clear all registers to 0 and all scoreboard bits to 0.
REQ-030 While reset=0: ReadData SHALL read 0 on every port, Busy SHALL be all 0, and writes and issues SHALL be ignored.
REQ-031 Reset asserted mid-operation SHALL discard pending writes and scoreboard state; the first edge after reset deasserts SHALL behave as a normal cycle.

Verification
REQ-032 Reset then read all 32 registers on both ports -> every ReadData=0, Busy=00.
REQ-033 Write 0xDEADBEEF_00000001 to x5, then read x5 next cycle -> that value; with BYPASS=1, a same-cycle read of x5 -> the value during the write cycle; with BYPASS=0 -> the old value (0).
REQ-034 Write 0xFFFF to x31 (ZERO_REG=31), then read x31 -> 0, and Busy stays 0 after issuing x31.
REQ-035 Issue x7, then read x7 -> Busy=1; write x7=0x42 -> Busy=0 in the write cycle (BYPASS=1) and data 0x42.
REQ-036 Issue x9 and write x9 in the same cycle -> the bit stays set and Busy=1 next cycle; also issue x3 and write x4 in one cycle -> x3 busy, x4 clear.
REQ-037 Assert reset for half a cycle with x2 busy and holding 0x7 -> immediately x2=0 and Busy=0; normal writes succeed on the next edge after release.
